// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single processor memory port; sequences wait states and returns read data.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
//   state    | meaning
//   S_IDLE   | port free, sampling REQ0/REQ1
//   S_ACCESS | strobe asserted, counting down wait states
//   S_DONE   | one-cycle completion pulse to the owner
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RDATA0,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  sel, sel_nx;
  logic                  win;
  logic                  tie_win;
  logic                  gnt0_nx, gnt1_nx, done0_nx, done1_nx;
  logic                  read_nx, write_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx, rdata0_nx, rdata1_nx;

`ifdef MEM_ARB_RR_EN
  logic last, last_nx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) last <= 1'b1;
    else      last <= last_nx;
  end

  assign tie_win = ~last;
`else
  assign tie_win = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      RDATA0    <= '0;
      RDATA1    <= '0;
      MEM_READ  <= 1'b0;
      MEM_WRITE <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sel       <= sel_nx;
      GNT0      <= gnt0_nx;
      GNT1      <= gnt1_nx;
      DONE0     <= done0_nx;
      DONE1     <= done1_nx;
      RDATA0    <= rdata0_nx;
      RDATA1    <= rdata1_nx;
      MEM_READ  <= read_nx;
      MEM_WRITE <= write_nx;
      MEM_ADDR  <= addr_nx;
      MEM_WDATA <= wdata_nx;
    end
  end

  // Winner is 1 only when requester 1 asks alone or wins a round-robin tie.
  assign win = (REQ0 & REQ1) ? tie_win : REQ1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sel_nx    = sel;
    gnt0_nx   = GNT0;
    gnt1_nx   = GNT1;
    done0_nx  = DONE0;
    done1_nx  = DONE1;
    rdata0_nx = RDATA0;
    rdata1_nx = RDATA1;
    read_nx   = MEM_READ;
    write_nx  = MEM_WRITE;
    addr_nx   = MEM_ADDR;
    wdata_nx  = MEM_WDATA;
`ifdef MEM_ARB_RR_EN
    last_nx   = last;
`endif
    case (state)
      S_IDLE: begin
        if (REQ0 | REQ1) begin
          state_nx = S_ACCESS;
          cnt_nx   = WS;
          sel_nx   = win;
          gnt0_nx  = ~win;
          gnt1_nx  = win;
          read_nx  = win ? ~WE1 : ~WE0;
          write_nx = win ? WE1 : WE0;
          addr_nx  = win ? ADDR1 : ADDR0;
          if (win) wdata_nx = WE1 ? WDATA1 : '0;
          else     wdata_nx = WE0 ? WDATA0 : '0;
`ifdef MEM_ARB_RR_EN
          last_nx  = win;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          if (MEM_READ) begin
            if (sel) rdata1_nx = MEM_RDATA;
            else     rdata0_nx = MEM_RDATA;
          end
          read_nx  = 1'b0;
          write_nx = 1'b0;
          addr_nx  = '0;
          wdata_nx = '0;
          done0_nx = ~sel;
          done1_nx = sel;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        done0_nx = 1'b0;
        done1_nx = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign BUSY = (state != S_IDLE);

endmodule
